// File: rtl/oai21_arc_seq.sv
// rtl/oai21_arc_seq.sv - timing-arc stimulus sequencer and checker for one OAI21 cell
//
// Walks the five timing arcs of an OAI21 cell (ZN = ~(A & (B1|B2))), rise then
// fall for each, giving ten steps. Every step has a PRE phase that holds the
// sensitizing vector and a POST phase after one input edge. ZN is sampled at
// the end of each phase and compared with the ideal cell response. Failing
// steps are recorded in a mask and a saturating counter.
//
// Ports
//   ck_i         clock, rising edge
//   rst_i        asynchronous reset, active-high
//   start_i      start request, honoured only while idle
//   zn_i         output of the cell under test
//   a_o          drive to cell pin A
//   b1_o         drive to cell pin B1
//   b2_o         drive to cell pin B2
//   busy_o       high from start acceptance through the done cycle
//   done_o       one-cycle pulse at the end of the sequence
//   step_o       current step 0..9 (arc = step>>1, step[0]: 0 rise, 1 fall)
//   fail_cnt_o   number of failed steps, saturating
//   fail_mask_o  bit n set when step n failed
//
// Parameters
//   SETTLE       cycles each phase is held before ZN is sampled (>=1)
//   CNT_W        width of fail_cnt_o (>=1)

module oai21_arc_seq #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 4
) (
  input  logic             ck_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             zn_i,
  output logic             a_o,
  output logic             b1_o,
  output logic             b2_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       step_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [9:0]       fail_mask_o
);

  // Phase timer is loaded with SETTLE-1 and counts down to 0, so every
  // phase occupies exactly SETTLE cycles.
  localparam int              TW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0]   TMR_LOAD  = TW'(SETTLE - 1);
  localparam logic [3:0]      LAST_STEP = 4'd9;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_POST,
    S_FIN
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    tmr_q;
  logic             a_q;
  logic             b1_q;
  logic             b2_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       step_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [9:0]       fail_mask_q;
  logic             pre_fail_q;

  logic [3:0]       step_d;
  logic             zn_exp;
  logic             zn_bad;
  logic             step_fail;
  logic [9:0]       step_bit;
  logic [2:0]       post_vec;
  logic [2:0]       next_pre_vec;

  // Drive vector {A,B1,B2} for a step. The toggling pin sits at 0 before a
  // rise edge and at 1 before a fall edge; the other two pins hold the
  // sensitizing values for that arc.
  function automatic logic [2:0] vec_f(input logic [3:0] step, input logic post);
    logic       lvl;
    logic [2:0] v;
    lvl = post ^ step[0];
    case (step[3:1])
      3'd0:    v = {lvl, 1'b0, 1'b1};
      3'd1:    v = {lvl, 1'b1, 1'b0};
      3'd2:    v = {lvl, 1'b1, 1'b1};
      3'd3:    v = {1'b1, lvl, 1'b0};
      3'd4:    v = {1'b1, 1'b0, lvl};
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // The expected ZN is the ideal cell evaluated on the vector currently
  // being driven, which is the same vector the cell has been settling on.
  always_comb begin
    zn_exp       = ~(a_q & (b1_q | b2_q));
    zn_bad       = (zn_i != zn_exp);
    step_fail    = pre_fail_q | zn_bad;
    step_d       = step_q + 4'd1;
    step_bit     = 10'(1) << step_q;
    post_vec     = vec_f(step_q, 1'b1);
    next_pre_vec = vec_f(step_d, 1'b0);
  end

  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      a_q         <= 1'b0;
      b1_q        <= 1'b0;
      b2_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_q      <= 4'd0;
      fail_cnt_q  <= '0;
      fail_mask_q <= '0;
      pre_fail_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          {a_q, b1_q, b2_q} <= 3'b000;
          step_q            <= 4'd0;
          done_q            <= 1'b0;
          busy_q            <= 1'b0;
          if (start_i) begin
            // Results of the previous run are kept until this point.
            fail_cnt_q        <= '0;
            fail_mask_q       <= '0;
            pre_fail_q        <= 1'b0;
            {a_q, b1_q, b2_q} <= vec_f(4'd0, 1'b0);
            tmr_q             <= TMR_LOAD;
            busy_q            <= 1'b1;
            state_q           <= S_PRE;
          end
        end

        S_PRE: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
          end else begin
            pre_fail_q        <= zn_bad;
            {a_q, b1_q, b2_q} <= post_vec;
            tmr_q             <= TMR_LOAD;
            state_q           <= S_POST;
          end
        end

        S_POST: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
          end else begin
            // A step is logged once, whichever phase (or both) failed.
            if (step_fail) begin
              fail_mask_q <= fail_mask_q | step_bit;
              if (fail_cnt_q != CNT_MAX) begin
                fail_cnt_q <= fail_cnt_q + CNT_W'(1);
              end
            end
            pre_fail_q <= 1'b0;
            if (step_q == LAST_STEP) begin
              {a_q, b1_q, b2_q} <= 3'b000;
              done_q            <= 1'b1;
              state_q           <= S_FIN;
            end else begin
              step_q            <= step_d;
              {a_q, b1_q, b2_q} <= next_pre_vec;
              tmr_q             <= TMR_LOAD;
              state_q           <= S_PRE;
            end
          end
        end

        S_FIN: begin
          // Single done cycle; start requests seen here are dropped.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          step_q  <= 4'd0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a_o         = a_q;
  assign b1_o        = b1_q;
  assign b2_o        = b2_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign step_o      = step_q;
  assign fail_cnt_o  = fail_cnt_q;
  assign fail_mask_o = fail_mask_q;

endmodule
